// File: rtl/pipe_clock_ctrl_if.sv
// Control/status bundle between the stage-clock generator and the board-level
// debug controller that steers it.
interface pipe_clock_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 I_PLL_LOCKED;
  logic                 I_RUN;
  logic                 I_STEP;
  logic                 O_CLK;
  logic                 O_CLK_RISE;
  logic                 O_LOCK;
  logic [1:0]           O_STATE;
  logic [CNT_WIDTH-1:0] O_CYCLE_COUNT;

  modport master (
    output I_PLL_LOCKED, I_RUN, I_STEP,
    input  O_CLK, O_CLK_RISE, O_LOCK, O_STATE, O_CYCLE_COUNT
  );

  modport slave (
    input  I_PLL_LOCKED, I_RUN, I_STEP,
    output O_CLK, O_CLK_RISE, O_LOCK, O_STATE, O_CYCLE_COUNT
  );
endinterface

// File: rtl/pipe_clock_ctrl.sv
// Pipeline stage clock generator: divides the PLL clock, holds lock through a
// warm-up window, and supports free-run / single-step debug operation.
module pipe_clock_ctrl #(
  parameter int DIV_COUNT = 10,
  parameter int LOCK_HOLD = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic             I_CLOCK,
  input  logic             I_RESET,
  pipe_clock_ctrl_if.slave bus
);
  localparam int WARM_W = $clog2(LOCK_HOLD + 1);
  localparam logic [CNT_WIDTH-1:0] DIV_TC  = CNT_WIDTH'(DIV_COUNT);
  localparam logic [WARM_W-1:0]    WARM_TC = WARM_W'(LOCK_HOLD);

  typedef enum logic [1:0] {
    WAIT_PLL  = 2'd0,
    WARMUP    = 2'd1,
    RUN       = 2'd2,
    STEP_HOLD = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [WARM_W-1:0]    warm_q, warm_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 lock_q, lock_d;
  logic                 act_q, act_d;
  logic                 step_q;
  logic                 wrap;
  logic                 step_edge;

  assign wrap      = (cnt_q == DIV_TC);
  assign step_edge = bus.I_STEP && !step_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    warm_d  = warm_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    lock_d  = lock_q;
    act_d   = act_q;
    if (state_q != WAIT_PLL && !bus.I_PLL_LOCKED) begin
      state_d = WAIT_PLL;
      cnt_d   = '0;
      cyc_d   = '0;
      warm_d  = '0;
      clk_d   = 1'b0;
      lock_d  = 1'b0;
      act_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_PLL: begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (bus.I_PLL_LOCKED) state_d = WARMUP;
        end
        WARMUP: begin
          if (wrap) begin
            cnt_d = '0;
            clk_d = !clk_q;
            if (!clk_q) begin
              rise_d = 1'b1;
              if (warm_q != WARM_TC) warm_d = warm_q + WARM_W'(1);
            end else if (warm_q == WARM_TC) begin
              // Lock goes up on the fall that closes the last warm-up pulse.
              lock_d  = 1'b1;
              state_d = bus.I_RUN ? RUN : STEP_HOLD;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        RUN: begin
          if (wrap) begin
            cnt_d = '0;
            if (clk_q) begin
              clk_d = 1'b0;
            end else if (!bus.I_RUN) begin
              state_d = STEP_HOLD;
            end else begin
              clk_d  = 1'b1;
              rise_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        STEP_HOLD: begin
          if (!act_q) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (bus.I_RUN)      state_d = RUN;
            else if (step_edge) act_d   = 1'b1;
          end else if (!clk_q) begin
            clk_d  = 1'b1;
            rise_d = 1'b1;
            cnt_d  = '0;
          end else if (wrap) begin
            // A run request arriving mid-step waits for the pulse to finish.
            clk_d = 1'b0;
            cnt_d = '0;
            act_d = 1'b0;
            if (bus.I_RUN) state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = WAIT_PLL;
      endcase
    end
    if (rise_d && lock_q) cyc_d = cyc_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q <= WAIT_PLL;
      cnt_q   <= '0;
      cyc_q   <= '0;
      warm_q  <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      lock_q  <= 1'b0;
      act_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      warm_q  <= warm_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      lock_q  <= lock_d;
      act_q   <= act_d;
      step_q  <= bus.I_STEP;
    end
  end

  assign bus.O_CLK         = clk_q;
  assign bus.O_CLK_RISE    = rise_q;
  assign bus.O_LOCK        = lock_q;
  assign bus.O_STATE       = state_q;
  assign bus.O_CYCLE_COUNT = cyc_q;
endmodule
